// File: rtl/memory_access_stage.sv
// Memory-access stage between EX and WB. It holds one instruction, issues its load/store on a request/response bus and aligns the load data.
// Latency: an ALU op reaches WB one cycle after accept. A load/store reaches WB three cycles after accept, plus one cycle per bus wait.
// Backpressure: io_allow_in is low while a bus transaction is in flight or while a held result is blocked by wb_allow_in.
module memory_access_stage #(
   parameter int DATA_WIDTH             = 32,
   parameter int ADDRESS_WIDTH          = 32,
   parameter int REGISTER_ADDRESS_WIDTH = 5
) (
   input  logic                              clock,
   input  logic                              reset_n,
   input  logic                              ex_valid,
   output logic                              io_allow_in,
   input  logic [ADDRESS_WIDTH-1:0]          ex_program_count,
   input  logic [DATA_WIDTH-1:0]             ex_alu_result,
   input  logic [DATA_WIDTH-1:0]             ex_store_data,
   input  logic                              ex_memory_read,
   input  logic                              ex_memory_write,
   input  logic [1:0]                        ex_access_size,
   input  logic                              ex_load_unsigned,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] ex_destination_register,
   input  logic                              ex_register_write,
   output logic                              data_request,
   output logic                              data_write,
   output logic [ADDRESS_WIDTH-1:0]          data_address,
   output logic [DATA_WIDTH-1:0]             data_write_data,
   output logic [DATA_WIDTH/8-1:0]           data_write_strobe,
   input  logic                              data_address_ok,
   input  logic                              data_ok,
   input  logic [DATA_WIDTH-1:0]             data_read_data,
   input  logic                              wb_allow_in,
   output logic                              wb_valid,
   output logic [ADDRESS_WIDTH-1:0]          wb_program_count,
   output logic                              wb_register_write,
   output logic [REGISTER_ADDRESS_WIDTH-1:0] wb_register_address,
   output logic [DATA_WIDTH-1:0]             wb_result,
   output logic                              address_error,
   output logic                              forward_valid,
   output logic                              forward_pending,
   output logic [REGISTER_ADDRESS_WIDTH-1:0] forward_register,
   output logic [DATA_WIDTH-1:0]             forward_data
);

   localparam int LANES        = DATA_WIDTH / 8;
   localparam int OFFSET_WIDTH = $clog2(LANES);
   localparam int INDEX_WIDTH  = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_REQUEST,
      ST_WAIT,
      ST_DONE
   } state_t;

   // Held instruction and FSM state
   state_t                            r_state;
   logic                              r_busy;
   logic                              r_data_request;
   logic                              r_wb_valid;
   logic [ADDRESS_WIDTH-1:0]          r_program_count;
   logic [ADDRESS_WIDTH-1:0]          r_address;
   logic [DATA_WIDTH-1:0]             r_write_data;
   logic [LANES-1:0]                  r_write_strobe;
   logic                              r_memory_read;
   logic                              r_memory_write;
   logic [1:0]                        r_access_size;
   logic                              r_load_unsigned;
   logic [OFFSET_WIDTH-1:0]           r_offset;
   logic [REGISTER_ADDRESS_WIDTH-1:0] r_destination;
   logic                              r_register_write;
   logic                              r_address_error;
   logic [DATA_WIDTH-1:0]             r_result;

   // Accept-side decode
   logic                    w_accept;
   logic                    w_is_memory;
   logic [2:0]              w_align_mask;
   logic                    w_misaligned;
   logic [OFFSET_WIDTH-1:0] w_offset;
   logic [LANES-1:0]        w_lane_mask;
   logic [LANES-1:0]        w_store_strobe;
   logic [DATA_WIDTH-1:0]   w_store_data;

   // Response-side alignment
   logic [DATA_WIDTH-1:0]   w_read_shifted;
   logic [7:0]              w_load_bits;
   logic [INDEX_WIDTH-1:0]  w_sign_index;
   logic [DATA_WIDTH-1:0]   w_keep_mask;
   logic                    w_load_fill;
   logic [DATA_WIDTH-1:0]   w_load_data;

   // Reset gates the handshake so nothing is offered to EX while reset is asserted
   assign io_allow_in = reset_n & (~r_busy | (r_wb_valid & wb_allow_in));
   assign w_accept    = ex_valid & io_allow_in;
   assign w_is_memory = ex_memory_read | ex_memory_write;
   assign w_offset    = ex_alu_result[OFFSET_WIDTH-1:0];

   // Misalignment: address low bits must be a multiple of the access size; double needs a 64-bit datapath
   always_comb begin
      w_align_mask = 3'b000;
      case (ex_access_size)
         2'd0:    w_align_mask = 3'b000;
         2'd1:    w_align_mask = 3'b001;
         2'd2:    w_align_mask = 3'b011;
         default: w_align_mask = 3'b111;
      endcase
      w_misaligned = w_is_memory &
                     ((|(ex_alu_result[2:0] & w_align_mask)) |
                      ((ex_access_size == 2'd3) && (DATA_WIDTH < 64)));
   end

   // Store formatting: replicate the value across all lanes; the strobe selects the lanes that get written
   always_comb begin
      w_store_data = ex_store_data;
      w_lane_mask  = '1;
      case (ex_access_size)
         2'd0: begin
            w_store_data = {LANES{ex_store_data[7:0]}};
            w_lane_mask  = LANES'(1);
         end
         2'd1: begin
            w_store_data = {(LANES/2){ex_store_data[15:0]}};
            w_lane_mask  = LANES'(3);
         end
         2'd2: begin
            w_store_data = {(LANES/4){ex_store_data[31:0]}};
            w_lane_mask  = LANES'(15);
         end
         default: begin
            w_store_data = ex_store_data;
            w_lane_mask  = '1;
         end
      endcase
      w_store_strobe = w_lane_mask << w_offset;
   end

   // Load alignment: shift the addressed lanes down, then sign- or zero-fill above the access width
   always_comb begin
      w_read_shifted = data_read_data >> {r_offset, 3'b000};
      w_load_bits    = 8'd64;
      case (r_access_size)
         2'd0:    w_load_bits = 8'd8;
         2'd1:    w_load_bits = 8'd16;
         2'd2:    w_load_bits = 8'd32;
         default: w_load_bits = 8'd64;
      endcase
      // A shift by the full width clears the fill region, so full-width loads pass straight through
      w_keep_mask  = ~({DATA_WIDTH{1'b1}} << w_load_bits);
      w_sign_index = INDEX_WIDTH'(w_load_bits - 8'd1);
      w_load_fill  = ~r_load_unsigned & w_read_shifted[w_sign_index];
      w_load_data  = (w_read_shifted & w_keep_mask) | ({DATA_WIDTH{w_load_fill}} & ~w_keep_mask);
   end

   // Stage FSM: capture on accept, run the bus handshake, hold the result until WB takes it
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state          <= ST_EMPTY;
         r_busy           <= 1'b0;
         r_data_request   <= 1'b0;
         r_wb_valid       <= 1'b0;
         r_program_count  <= '0;
         r_address        <= '0;
         r_write_data     <= '0;
         r_write_strobe   <= '0;
         r_memory_read    <= 1'b0;
         r_memory_write   <= 1'b0;
         r_access_size    <= 2'd0;
         r_load_unsigned  <= 1'b0;
         r_offset         <= '0;
         r_destination    <= '0;
         r_register_write <= 1'b0;
         r_address_error  <= 1'b0;
         r_result         <= '0;
      end else begin
         case (r_state)
            ST_REQUEST: begin
               // Any data_ok seen here belongs to no transaction of ours and is ignored
               if (data_address_ok) begin
                  r_state        <= ST_WAIT;
                  r_data_request <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (data_ok) begin
                  if (r_memory_read) begin
                     r_result <= w_load_data;
                  end
                  r_state    <= ST_DONE;
                  r_wb_valid <= 1'b1;
               end
            end
            default: begin
               // EMPTY and DONE both accept; DONE only when WB drains it in the same cycle
               if (w_accept) begin
                  r_busy           <= 1'b1;
                  r_program_count  <= ex_program_count;
                  r_address        <= ADDRESS_WIDTH'(ex_alu_result);
                  r_write_data     <= ex_memory_write ? w_store_data : '0;
                  r_write_strobe   <= ex_memory_write ? w_store_strobe : '0;
                  r_memory_read    <= ex_memory_read;
                  r_memory_write   <= ex_memory_write;
                  r_access_size    <= ex_access_size;
                  r_load_unsigned  <= ex_load_unsigned;
                  r_offset         <= w_offset;
                  r_destination    <= ex_destination_register;
                  r_register_write <= ex_register_write & ~w_misaligned;
                  r_address_error  <= w_misaligned;
                  r_result         <= ex_alu_result;
                  if (w_is_memory && !w_misaligned) begin
                     r_state        <= ST_REQUEST;
                     r_data_request <= 1'b1;
                     r_wb_valid     <= 1'b0;
                  end else begin
                     r_state        <= ST_DONE;
                     r_data_request <= 1'b0;
                     r_wb_valid     <= 1'b1;
                  end
               end else if (r_wb_valid && wb_allow_in) begin
                  r_state         <= ST_EMPTY;
                  r_busy          <= 1'b0;
                  r_wb_valid      <= 1'b0;
                  r_address_error <= 1'b0;
               end
            end
         endcase
      end
   end

   assign data_request      = r_data_request;
   assign data_write        = r_data_request & r_memory_write;
   assign data_address      = r_address;
   assign data_write_data   = r_write_data;
   assign data_write_strobe = r_write_strobe;

   assign wb_valid            = r_wb_valid;
   assign wb_program_count    = r_program_count;
   assign wb_register_write   = r_register_write;
   assign wb_register_address = r_destination;
   assign wb_result           = r_result;
   assign address_error       = r_address_error;

   // A load still on the bus has no data yet, so ID must stall on its destination
   assign forward_valid    = r_busy & r_register_write;
   assign forward_pending  = forward_valid & r_memory_read & ~r_wb_valid;
   assign forward_register = r_destination;
   assign forward_data     = r_result;

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: 32-bit and 64-bit instances share stimulus and are checked against a reference model.
// Latency: the bench follows each transaction cycle by cycle from accept until the stage is empty again.
// Backpressure: wb_allow_in is held low for random stretches, and bus handshakes are delayed randomly.
module tb_memory_access_stage;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset_n;
   logic        v32, v64;
   logic [31:0] ex_pc;
   logic [63:0] ex_alu, ex_sd, rdat;
   logic        ex_rd, ex_wr, ex_uns, ex_rw;
   logic [1:0]  ex_size;
   logic [4:0]  ex_dst;
   logic        aok, dok, wb_allow;

   logic        a_allow, a_req, a_wr, a_wbv, a_wbrw, a_aerr, a_fv, a_fp;
   logic [31:0] a_addr, a_wdata, a_wbpc, a_res, a_fdata;
   logic [3:0]  a_strb;
   logic [4:0]  a_wbra, a_freg;

   logic        b_allow, b_req, b_wr, b_wbv, b_wbrw, b_aerr, b_fv, b_fp;
   logic [31:0] b_addr, b_wbpc;
   logic [63:0] b_wdata, b_res, b_fdata;
   logic [7:0]  b_strb;
   logic [4:0]  b_wbra, b_freg;

   memory_access_stage #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .REGISTER_ADDRESS_WIDTH(5)) dut32 (
      .clock(clock), .reset_n(reset_n), .ex_valid(v32), .io_allow_in(a_allow),
      .ex_program_count(ex_pc), .ex_alu_result(ex_alu[31:0]), .ex_store_data(ex_sd[31:0]),
      .ex_memory_read(ex_rd), .ex_memory_write(ex_wr), .ex_access_size(ex_size),
      .ex_load_unsigned(ex_uns), .ex_destination_register(ex_dst), .ex_register_write(ex_rw),
      .data_request(a_req), .data_write(a_wr), .data_address(a_addr),
      .data_write_data(a_wdata), .data_write_strobe(a_strb),
      .data_address_ok(aok), .data_ok(dok), .data_read_data(rdat[31:0]),
      .wb_allow_in(wb_allow), .wb_valid(a_wbv), .wb_program_count(a_wbpc),
      .wb_register_write(a_wbrw), .wb_register_address(a_wbra), .wb_result(a_res),
      .address_error(a_aerr), .forward_valid(a_fv), .forward_pending(a_fp),
      .forward_register(a_freg), .forward_data(a_fdata));

   memory_access_stage #(.DATA_WIDTH(64), .ADDRESS_WIDTH(32), .REGISTER_ADDRESS_WIDTH(5)) dut64 (
      .clock(clock), .reset_n(reset_n), .ex_valid(v64), .io_allow_in(b_allow),
      .ex_program_count(ex_pc), .ex_alu_result(ex_alu), .ex_store_data(ex_sd),
      .ex_memory_read(ex_rd), .ex_memory_write(ex_wr), .ex_access_size(ex_size),
      .ex_load_unsigned(ex_uns), .ex_destination_register(ex_dst), .ex_register_write(ex_rw),
      .data_request(b_req), .data_write(b_wr), .data_address(b_addr),
      .data_write_data(b_wdata), .data_write_strobe(b_strb),
      .data_address_ok(aok), .data_ok(dok), .data_read_data(rdat),
      .wb_allow_in(wb_allow), .wb_valid(b_wbv), .wb_program_count(b_wbpc),
      .wb_register_write(b_wbrw), .wb_register_address(b_wbra), .wb_result(b_res),
      .address_error(b_aerr), .forward_valid(b_fv), .forward_pending(b_fp),
      .forward_register(b_freg), .forward_data(b_fdata));

   typedef struct {
      logic        allow, req, wr, wbv, wbrw, aerr, fv, fp;
      logic [31:0] addr, wbpc;
      logic [63:0] wdata, res, fdata;
      logic [7:0]  strb;
      logic [4:0]  wbra, freg;
   } obs_t;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic obs_t sample(input int w);
      obs_t o;
      if (w == 32) begin
         o.allow = a_allow; o.req = a_req; o.wr = a_wr; o.wbv = a_wbv; o.wbrw = a_wbrw;
         o.aerr = a_aerr; o.fv = a_fv; o.fp = a_fp; o.addr = a_addr; o.wbpc = a_wbpc;
         o.wdata = {32'd0, a_wdata}; o.res = {32'd0, a_res}; o.fdata = {32'd0, a_fdata};
         o.strb = {4'd0, a_strb}; o.wbra = a_wbra; o.freg = a_freg;
      end else begin
         o.allow = b_allow; o.req = b_req; o.wr = b_wr; o.wbv = b_wbv; o.wbrw = b_wbrw;
         o.aerr = b_aerr; o.fv = b_fv; o.fp = b_fp; o.addr = b_addr; o.wbpc = b_wbpc;
         o.wdata = b_wdata; o.res = b_res; o.fdata = b_fdata;
         o.strb = b_strb; o.wbra = b_wbra; o.freg = b_freg;
      end
      return o;
   endfunction

   // ---------------- reference model ----------------
   function automatic logic [63:0] wmask(input int w);
      return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
   endfunction

   function automatic bit model_mis(input int w, input logic [63:0] a, input logic [1:0] sz, input bit mem);
      if (!mem) return 1'b0;
      if (sz == 2'd3 && w == 32) return 1'b1;
      return (a % (64'd1 << sz)) != 0;
   endfunction

   function automatic logic [63:0] model_wdata(input int w, input logic [63:0] sd, input logic [1:0] sz);
      int bits;
      logic [63:0] unit, r;
      bits = 8 << sz;
      unit = (bits == 64) ? sd : (sd & ((64'd1 << bits) - 64'd1));
      r = 64'd0;
      for (int i = 0; i < w / bits; i++) r = r | (unit << (i * bits));
      return r;
   endfunction

   function automatic logic [63:0] model_strb(input int w, input logic [63:0] a, input logic [1:0] sz);
      int off;
      off = int'(a % (w / 8));
      return (((64'd1 << (1 << sz)) - 64'd1) << off) & ((64'd1 << (w / 8)) - 64'd1);
   endfunction

   function automatic logic [63:0] model_load(input int w, input logic [63:0] a, input logic [1:0] sz,
                                              input bit uns, input logic [63:0] rd);
      int off, bits;
      logic [63:0] d, m;
      off  = int'(a % (w / 8));
      bits = 8 << sz;
      d = (rd & wmask(w)) >> (off * 8);
      if (bits < 64) begin
         m = (64'd1 << bits) - 64'd1;
         if (!uns && d[bits-1]) d = d | ~m;
         else d = d & m;
      end
      return d & wmask(w);
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   // One transaction from accept to empty; both enabled instances must follow the same path
   task automatic txn(input bit e32, input bit e64, input bit rd, input bit wr, input logic [1:0] sz,
                      input bit uns, input logic [63:0] alu, input logic [63:0] sd, input logic [63:0] rdv,
                      input bit rw, input logic [4:0] dst, input int aok_d, input int dok_d, input int hold);
      bit en [2];
      int wv [2];
      bit mis [2];
      logic [63:0] exp_res [2];
      logic [31:0] pc;
      bit bus;
      obs_t o;
      en[0] = e32; en[1] = e64; wv[0] = 32; wv[1] = 64;
      pc = $urandom();
      for (int d = 0; d < 2; d++) begin
         mis[d] = model_mis(wv[d], alu, sz, rd | wr);
         exp_res[d] = (rd && !mis[d]) ? model_load(wv[d], alu, sz, uns, rdv) : (alu & wmask(wv[d]));
      end
      bus = (rd | wr) && !(e32 ? mis[0] : mis[1]);

      ex_pc = pc; ex_alu = alu; ex_sd = sd; ex_rd = rd; ex_wr = wr; ex_size = sz; ex_uns = uns;
      ex_rw = rw; ex_dst = dst; v32 = e32; v64 = e64; wb_allow = 1'b1;
      aok = 1'($urandom()); dok = 1'($urandom()); rdat = rnd64();
      #1;
      for (int d = 0; d < 2; d++) if (en[d]) begin
         o = sample(wv[d]);
         check($sformatf("w%0d accept_allow", wv[d]), o.allow, 1);
         check($sformatf("w%0d accept_wbv", wv[d]), o.wbv, 0);
      end
      @(negedge clock);
      v32 = 1'b0; v64 = 1'b0;
      ex_pc = $urandom(); ex_alu = rnd64(); ex_sd = rnd64(); ex_dst = 5'($urandom());

      if (bus) begin
         for (int k = 0; k <= aok_d; k++) begin
            aok = (k == aok_d); dok = 1'($urandom());
            #1;
            for (int d = 0; d < 2; d++) if (en[d]) begin
               o = sample(wv[d]);
               check($sformatf("w%0d req", wv[d]), o.req, 1);
               check($sformatf("w%0d req_addr", wv[d]), o.addr, alu[31:0]);
               check($sformatf("w%0d req_write", wv[d]), o.wr, wr);
               if (wr) begin
                  check($sformatf("w%0d req_wdata", wv[d]), o.wdata, model_wdata(wv[d], sd, sz));
                  check($sformatf("w%0d req_strobe", wv[d]), o.strb, model_strb(wv[d], alu, sz));
               end
               check($sformatf("w%0d req_wbv", wv[d]), o.wbv, 0);
               check($sformatf("w%0d req_allow", wv[d]), o.allow, 0);
               check($sformatf("w%0d req_fpend", wv[d]), o.fp, rd & rw);
            end
            @(negedge clock);
         end
         for (int k = 0; k <= dok_d; k++) begin
            dok = (k == dok_d); aok = 1'($urandom());
            rdat = (k == dok_d) ? rdv : rnd64();
            #1;
            for (int d = 0; d < 2; d++) if (en[d]) begin
               o = sample(wv[d]);
               check($sformatf("w%0d wait_req", wv[d]), o.req, 0);
               check($sformatf("w%0d wait_wbv", wv[d]), o.wbv, 0);
               check($sformatf("w%0d wait_allow", wv[d]), o.allow, 0);
               check($sformatf("w%0d wait_fvalid", wv[d]), o.fv, rw);
               check($sformatf("w%0d wait_fpend", wv[d]), o.fp, rd & rw);
            end
            @(negedge clock);
         end
      end

      aok = 1'b0;
      for (int k = 0; k <= hold; k++) begin
         wb_allow = (k == hold); dok = 1'($urandom()); rdat = rnd64();
         #1;
         for (int d = 0; d < 2; d++) if (en[d]) begin
            o = sample(wv[d]);
            check($sformatf("w%0d done_wbv", wv[d]), o.wbv, 1);
            check($sformatf("w%0d done_allow", wv[d]), o.allow, (k == hold));
            check($sformatf("w%0d done_req", wv[d]), o.req, 0);
            check($sformatf("w%0d done_pc", wv[d]), o.wbpc, pc);
            check($sformatf("w%0d done_result", wv[d]), o.res, exp_res[d]);
            check($sformatf("w%0d done_aerr", wv[d]), o.aerr, mis[d]);
            check($sformatf("w%0d done_rw", wv[d]), o.wbrw, rw & !mis[d]);
            check($sformatf("w%0d done_ra", wv[d]), o.wbra, dst);
            check($sformatf("w%0d done_fvalid", wv[d]), o.fv, rw & !mis[d]);
            check($sformatf("w%0d done_fpend", wv[d]), o.fp, 0);
            if (rw && !mis[d]) begin
               check($sformatf("w%0d done_freg", wv[d]), o.freg, dst);
               check($sformatf("w%0d done_fdata", wv[d]), o.fdata, exp_res[d]);
            end
         end
         @(negedge clock);
      end

      dok = 1'($urandom());
      #1;
      for (int d = 0; d < 2; d++) if (en[d]) begin
         o = sample(wv[d]);
         check($sformatf("w%0d empty_wbv", wv[d]), o.wbv, 0);
         check($sformatf("w%0d empty_req", wv[d]), o.req, 0);
         check($sformatf("w%0d empty_allow", wv[d]), o.allow, 1);
         check($sformatf("w%0d empty_fvalid", wv[d]), o.fv, 0);
      end
      @(negedge clock);
      dok = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      obs_t o;
      logic [63:0] prev;
      int op, e;
      logic [1:0] sz;
      logic [63:0] alu;

      reset_n = 1'b0; v32 = 1'b0; v64 = 1'b0; ex_pc = '0; ex_alu = '0; ex_sd = '0; rdat = '0;
      ex_rd = 1'b0; ex_wr = 1'b0; ex_uns = 1'b0; ex_rw = 1'b0; ex_size = 2'd0; ex_dst = '0;
      aok = 1'b0; dok = 1'b0; wb_allow = 1'b0;

      // reset held for two cycles
      repeat (2) @(negedge clock);
      #1;
      for (int w = 32; w <= 64; w += 32) begin
         o = sample(w);
         check($sformatf("w%0d rst_wbv", w), o.wbv, 0);
         check($sformatf("w%0d rst_req", w), o.req, 0);
         check($sformatf("w%0d rst_allow", w), o.allow, 0);
         check($sformatf("w%0d rst_fvalid", w), o.fv, 0);
         check($sformatf("w%0d rst_result", w), o.res, 0);
         check($sformatf("w%0d rst_aerr", w), o.aerr, 0);
      end
      reset_n = 1'b1;
      #1;
      check("w32 rst_release_allow", a_allow, 1);
      check("w64 rst_release_allow", b_allow, 1);
      @(negedge clock);

      // directed cases from the block's own examples
      txn(1, 1, 1, 0, 2'd0, 0, 64'h1003, 64'h0, 64'h0000_0000_80FF_0000, 1, 5'd5, 0, 0, 0);  // lb
      txn(1, 1, 1, 0, 2'd0, 1, 64'h1003, 64'h0, 64'h0000_0000_80FF_0000, 1, 5'd6, 0, 0, 0);  // lbu
      txn(1, 1, 0, 1, 2'd1, 0, 64'h1002, 64'h1234, 64'h0, 0, 5'd0, 3, 0, 0);                 // sh, slow addr_ok
      txn(1, 1, 1, 0, 2'd2, 0, 64'h1001, 64'h0, 64'h0, 1, 5'd9, 0, 0, 0);                    // misaligned lw
      txn(0, 1, 1, 0, 2'd3, 0, 64'h2000, 64'h0, 64'h8000_0000_0000_0001, 1, 5'd7, 1, 2, 0);  // ld
      txn(0, 1, 1, 0, 2'd2, 0, 64'h2004, 64'h0, 64'h8000_0000_1234_5678, 1, 5'd8, 0, 0, 0);  // lw upper half
      txn(1, 0, 1, 0, 2'd3, 0, 64'h2000, 64'h0, 64'h0, 1, 5'd4, 0, 0, 0);                    // ld on 32-bit
      txn(0, 1, 0, 1, 2'd3, 0, 64'h2008, 64'hDEAD_BEEF_0BAD_F00D, 64'h0, 0, 5'd0, 0, 1, 0);  // sd
      txn(1, 1, 1, 0, 2'd2, 0, 64'h1000, 64'h0, 64'h0000_0000_CAFE_F00D, 1, 5'd3, 1, 2, 2);  // stalls

      // back-to-back ALU ops
      wb_allow = 1'b1;
      prev = '0;
      for (int i = 0; i < 4; i++) begin
         ex_alu = rnd64(); ex_rd = 1'b0; ex_wr = 1'b0; ex_rw = 1'b1; ex_dst = 5'(i + 1);
         ex_pc = 32'(i * 4); v32 = 1'b1; v64 = 1'b1;
         #1;
         check("w32 b2b_allow", a_allow, 1);
         check("w64 b2b_allow", b_allow, 1);
         if (i > 0) begin
            check("w32 b2b_wbv", a_wbv, 1);
            check("w32 b2b_result", {32'd0, a_res}, prev & wmask(32));
            check("w64 b2b_result", b_res, prev);
         end
         @(negedge clock);
         prev = ex_alu;
      end
      v32 = 1'b0; v64 = 1'b0;
      #1;
      check("w32 b2b_last", {32'd0, a_res}, prev & wmask(32));
      check("w64 b2b_last", b_res, prev);
      @(negedge clock);
      #1;
      check("w32 b2b_drained", a_wbv, 0);
      check("w64 b2b_drained", b_wbv, 0);
      @(negedge clock);

      // reset while a load waits for its response
      ex_alu = 64'h3000; ex_rd = 1'b1; ex_wr = 1'b0; ex_size = 2'd2; ex_uns = 1'b0; ex_rw = 1'b1;
      ex_dst = 5'd11; v32 = 1'b1; v64 = 1'b1; aok = 1'b0; dok = 1'b0;
      @(negedge clock);
      v32 = 1'b0; v64 = 1'b0; aok = 1'b1;
      #1;
      check("w32 rstw_req", a_req, 1);
      check("w64 rstw_req", b_req, 1);
      @(negedge clock);
      aok = 1'b0;
      #1;
      check("w32 rstw_pend", a_fp, 1);
      check("w64 rstw_pend", b_fp, 1);
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1; dok = 1'b1; rdat = rnd64();
      #1;
      for (int w = 32; w <= 64; w += 32) begin
         o = sample(w);
         check($sformatf("w%0d rstw_wbv", w), o.wbv, 0);
         check($sformatf("w%0d rstw_allow", w), o.allow, 1);
         check($sformatf("w%0d rstw_fvalid", w), o.fv, 0);
      end
      @(negedge clock);
      dok = 1'b0;
      #1;
      for (int w = 32; w <= 64; w += 32) begin
         o = sample(w);
         check($sformatf("w%0d rstw_after_wbv", w), o.wbv, 0);
         check($sformatf("w%0d rstw_after_result", w), o.res, 0);
      end
      @(negedge clock);

      // randomized traffic
      for (int i = 0; i < 200; i++) begin
         op = $urandom_range(0, 2);
         sz = 2'($urandom_range(0, 3));
         alu = rnd64();
         if ($urandom_range(0, 1) == 1) alu = alu & ~((64'd1 << sz) - 64'd1);
         e = (sz == 2'd3) ? $urandom_range(1, 2) : 3;
         txn(e[0], e[1], (op == 1), (op == 2), sz, 1'($urandom()), alu, rnd64(), rnd64(),
             (op != 2) ? 1'($urandom()) : 1'b0, 5'($urandom()),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
